// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial frame receiver with trailing parity check
//
// Collects DATA_BITS serial data bits (LSB first), keeps a running XOR
// of them, then compares the next bit against the expected parity bit
// (XOR of the data, inverted when ODD_PARITY=1). Each completed frame
// produces a one-cycle frame_done with the reassembled word and a
// pass/fail flag.
//
// Optional feature macro: PARITY_ERR_COUNT_EN adds a saturating 8-bit
// count of frames that completed with a parity error.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bit_in     serial data bit, sampled when bit_valid=1
//   bit_valid  qualifies bit_in for one cycle
//   abort      discards the frame in progress
//   busy       1 while a frame is in progress
//   frame_done one-cycle pulse, par_err/data_out just updated
//   par_err    1 = received parity mismatched; held until next frame_done
//   data_out   reassembled word; held until next frame_done
//   err_count  (PARITY_ERR_COUNT_EN only) saturating bad-frame count
module serial_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 abort,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 par_err,
  output logic [DATA_BITS-1:0] data_out
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  localparam int            CW   = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS);
  localparam logic          ODD  = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 acc;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        cnt_inc;
  logic                 mismatch;

  assign cnt_inc  = cnt + CW'(1);
  // Received parity bit versus the parity the data bits call for.
  assign mismatch = bit_in ^ acc ^ ODD;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= 1'b0;
      shreg      <= '0;
      frame_done <= 1'b0;
      par_err    <= 1'b0;
      data_out   <= '0;
`ifdef PARITY_ERR_COUNT_EN
      err_count  <= 8'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        // Abort beats a coincident bit; reported results are left alone.
        if (state != IDLE) begin
          state <= IDLE;
          cnt   <= '0;
          acc   <= 1'b0;
        end
      end else if (bit_valid) begin
        case (state)
          IDLE: begin
            // First bit restarts the shift register so stale upper bits
            // from the previous frame never leak into this word.
            shreg <= DATA_BITS'(bit_in);
            acc   <= bit_in;
            cnt   <= CW'(1);
            state <= (DATA_BITS == 1) ? PAR : DATA;
          end
          DATA: begin
            shreg <= shreg | (DATA_BITS'(bit_in) << cnt);
            acc   <= acc ^ bit_in;
            cnt   <= cnt_inc;
            if (cnt_inc == LAST) begin
              state <= PAR;
            end
          end
          PAR: begin
            frame_done <= 1'b1;
            par_err    <= mismatch;
            data_out   <= shreg;
            state      <= IDLE;
            cnt        <= '0;
            acc        <= 1'b0;
`ifdef PARITY_ERR_COUNT_EN
            if (mismatch && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
`endif
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - scoreboard bench for serial_parity_checker
module tb_serial_parity_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: DATA_BITS=8 even, 1: DATA_BITS=8 odd, 2: DATA_BITS=1 even.
  logic [2:0] rst_n;
  logic [2:0] bit_in;
  logic [2:0] bit_valid;
  logic [2:0] abort;
  logic [2:0] busy;
  logic [2:0] frame_done;
  logic [2:0] par_err;
  logic [7:0] data_out0;
  logic [7:0] data_out1;
  logic [0:0] data_out2;
`ifdef PARITY_ERR_COUNT_EN
  logic [7:0] ec0;
  logic [7:0] ec1;
  logic [7:0] ec2;
`endif

  int checks = 0;
  int passes = 0;
  int fd_count0 = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [1:0] q2[$];

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst_n(rst_n[0]), .bit_in(bit_in[0]), .bit_valid(bit_valid[0]),
    .abort(abort[0]), .busy(busy[0]), .frame_done(frame_done[0]),
    .par_err(par_err[0]), .data_out(data_out0)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(ec0)
`endif
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n[1]), .bit_in(bit_in[1]), .bit_valid(bit_valid[1]),
    .abort(abort[1]), .busy(busy[1]), .frame_done(frame_done[1]),
    .par_err(par_err[1]), .data_out(data_out1)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(ec1)
`endif
  );

  serial_parity_checker #(.DATA_BITS(1), .ODD_PARITY(0)) dut_one (
    .clk(clk), .rst_n(rst_n[2]), .bit_in(bit_in[2]), .bit_valid(bit_valid[2]),
    .abort(abort[2]), .busy(busy[2]), .frame_done(frame_done[2]),
    .par_err(par_err[2]), .data_out(data_out2)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(ec2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitors: every frame_done pops one expected {err, data} entry.
  always @(negedge clk) begin
    if (frame_done[0]) begin
      fd_count0++;
      check("even_expected_frame", (q0.size() != 0), 1);
      if (q0.size() != 0) begin
        logic [8:0] e;
        e = q0.pop_front();
        check("even_data_out", data_out0, e[7:0]);
        check("even_par_err", par_err[0], e[8]);
      end
    end
    if (frame_done[1]) begin
      check("odd_expected_frame", (q1.size() != 0), 1);
      if (q1.size() != 0) begin
        logic [8:0] e;
        e = q1.pop_front();
        check("odd_data_out", data_out1, e[7:0]);
        check("odd_par_err", par_err[1], e[8]);
      end
    end
    if (frame_done[2]) begin
      check("one_expected_frame", (q2.size() != 0), 1);
      if (q2.size() != 0) begin
        logic [1:0] e;
        e = q2.pop_front();
        check("one_data_out", data_out2, e[0]);
        check("one_par_err", par_err[2], e[1]);
      end
    end
  end

  task automatic send_bit(input int k, input logic b);
    bit_in[k]    = b;
    bit_valid[k] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int n);
    bit_valid[k] = 1'b0;
    bit_in[k]    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int k, input logic [7:0] d, input logic e);
    case (k)
      0: q0.push_back({e, d});
      1: q1.push_back({e, d});
      default: q2.push_back({e, d[0]});
    endcase
  endtask

  // Data bits LSB first, optional gap cycles after each data bit, then parity.
  task automatic send_frame(input int k, input int nbits, input logic [7:0] d,
                            input logic p, input logic exp_err, input int gap,
                            input bit chk_busy);
    for (int i = 0; i < nbits; i++) begin
      send_bit(k, d[i]);
      if (chk_busy) check("busy_after_bit", busy[k], 1);
      if (gap > 0) begin
        idle(k, gap);
        if (chk_busy) check("busy_in_gap", busy[k], 1);
      end
    end
    push_exp(k, d, exp_err);
    send_bit(k, p);
    bit_valid[k] = 1'b0;
  endtask

  initial begin
    int base;
    rst_n     = 3'b000;
    bit_in    = 3'b000;
    bit_valid = 3'b000;
    abort     = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_par_err", par_err, 0);
    check("reset_data_out0", data_out0, 0);
    check("reset_data_out1", data_out1, 0);
    check("reset_data_out2", data_out2, 0);
`ifdef PARITY_ERR_COUNT_EN
    check("reset_err_count", {ec2, ec1, ec0}, 0);
`endif
    rst_n = 3'b111;
    idle(0, 1);

    // A5 has four ones: even parity bit 0 passes, 1 fails.
    send_frame(0, 8, 8'hA5, 1'b0, 1'b0, 0, 1'b0);
    check("latency_frame_done", frame_done[0], 1);
    check("busy_after_frame", busy[0], 0);
    idle(0, 1);
    check("frame_done_one_cycle", frame_done[0], 0);
    send_frame(0, 8, 8'hA5, 1'b1, 1'b1, 0, 1'b0);
    idle(0, 1);
`ifdef PARITY_ERR_COUNT_EN
    check("err_count_one", ec0, 1);
`endif

    // Odd parity: 00 wants parity 1, 01 wants parity 0.
    send_frame(1, 8, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    idle(1, 1);
    send_frame(1, 8, 8'h01, 1'b1, 1'b1, 0, 1'b0);
    idle(1, 1);

    // Single-bit frames back to back.
    send_frame(2, 1, 8'h01, 1'b1, 1'b0, 0, 1'b0);
    send_frame(2, 1, 8'h01, 1'b0, 1'b1, 0, 1'b0);
    send_frame(2, 1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    idle(2, 1);

    // bit_valid every third cycle; 3C has four ones.
    send_frame(0, 8, 8'h3C, 1'b0, 1'b0, 2, 1'b1);
    check("gap_frame_done", frame_done[0], 1);
    check("gap_busy_after", busy[0], 0);
    idle(0, 1);

    // Abort after three bits, coincident with a valid bit.
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    check("busy_before_abort", busy[0], 1);
    bit_in[0] = 1'b1;
    abort[0]  = 1'b1;
    @(posedge clk);
    #1;
    abort[0]     = 1'b0;
    bit_valid[0] = 1'b0;
    check("abort_busy", busy[0], 0);
    check("abort_keeps_data", data_out0, 8'h3C);
    check("abort_keeps_err", par_err[0], 0);
    idle(0, 2);
    send_frame(0, 8, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
    idle(0, 1);

    // Bad frame, then reset after five bits of the next one.
    send_frame(0, 8, 8'h3C, 1'b1, 1'b1, 0, 1'b0);
    idle(0, 1);
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    bit_valid[0] = 1'b0;
    rst_n[0]     = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_busy", busy[0], 0);
    check("midreset_frame_done", frame_done[0], 0);
    check("midreset_par_err", par_err[0], 0);
    check("midreset_data_out", data_out0, 0);
`ifdef PARITY_ERR_COUNT_EN
    check("midreset_err_count", ec0, 0);
`endif
    rst_n[0] = 1'b1;
    send_frame(0, 8, 8'hA5, 1'b0, 1'b0, 0, 1'b0);
    idle(0, 1);

    // 260 bad frames with bit_valid held every cycle.
    base = fd_count0;
    for (int f = 0; f < 260; f++) send_frame(0, 8, 8'hA5, 1'b1, 1'b1, 0, 1'b0);
    idle(0, 2);
    check("b2b_frame_count", fd_count0 - base, 260);
`ifdef PARITY_ERR_COUNT_EN
    check("err_count_saturated", ec0, 255);
`endif

    idle(0, 3);
    check("even_queue_drained", q0.size(), 0);
    check("odd_queue_drained", q1.size(), 0);
    check("one_queue_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
